// File: rtl/reg_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_pkg: shared defaults and types for reg_file_sb          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package reg_file_pkg;
  localparam int RF_DATA_W    = 32;
  localparam int RF_NREGS     = 8;
  localparam int RF_ADDR_W    = $clog2(RF_NREGS);
  localparam int RF_ZERO_ADDR = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_sb_if: decode/writeback bus of the register file        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              busy1;
  logic              busy2;
  logic              stall;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data1, rd_data2, busy1, busy2, stall
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, busy1, busy2, stall
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_scoreboard: per-register busy bits and stall generation |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_iss_en,
  input  logic [ADDR_W-1:0] i_iss_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_iss_busy,
  output logic              o_stall
);
  localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(RF_ZERO_ADDR);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic w_zero1, w_zero2, w_zero_iss;
  logic w_hit1, w_hit2, w_hit_iss;

  assign w_zero1    = (ZERO_REG != 0) && (i_rd_addr1 == c_zero);
  assign w_zero2    = (ZERO_REG != 0) && (i_rd_addr2 == c_zero);
  assign w_zero_iss = (ZERO_REG != 0) && (i_iss_addr == c_zero);
  assign w_hit1     = i_wr_en && (i_wr_addr == i_rd_addr1);
  assign w_hit2     = i_wr_en && (i_wr_addr == i_rd_addr2);
  assign w_hit_iss  = i_wr_en && (i_wr_addr == i_iss_addr);

  assign o_busy1    = r_busy[i_rd_addr1] && !((BYPASS != 0) && w_hit1) && !w_zero1;
  assign o_busy2    = r_busy[i_rd_addr2] && !((BYPASS != 0) && w_hit2) && !w_zero2;
  // The WAW guard ignores BYPASS: a retiring producer frees its slot either way.
  assign o_iss_busy = i_iss_en && r_busy[i_iss_addr] && !w_hit_iss && !w_zero_iss;
  assign o_stall    = o_busy1 || o_busy2 || o_iss_busy;

  // Set is applied after clear so a same-edge issue to the retiring register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en)
      w_busy_nxt[i_wr_addr] = 1'b0;
    if (i_iss_en && !o_stall && !w_zero_iss)
      w_busy_nxt[i_iss_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end
endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | reg_file_sb: 2R/1W register file with bypass and busy scoreboard |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  reg_file_sb_if.slave  bus
);
  localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(RF_ZERO_ADDR);

  logic [DATA_W-1:0] r_rf [NREGS];
  logic              w_wr_ok;
  logic              w_iss_busy;

  assign w_wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == c_zero));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Zero forcing sits last so it overrides a bypassed write to R0.
  always_comb begin
    bus.rd_data1 = r_rf[bus.rd_addr1];
    if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr1))
      bus.rd_data1 = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rd_addr1 == c_zero))
      bus.rd_data1 = '0;
  end

  always_comb begin
    bus.rd_data2 = r_rf[bus.rd_addr2];
    if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr2))
      bus.rd_data2 = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rd_addr2 == c_zero))
      bus.rd_data2 = '0;
  end

  reg_file_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .i_rd_addr1 (bus.rd_addr1),
    .i_rd_addr2 (bus.rd_addr2),
    .o_busy1    (bus.busy1),
    .o_busy2    (bus.busy2),
    .o_iss_busy (w_iss_busy),
    .o_stall    (bus.stall)
  );
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_reg_file_sb: directed and random checks of reg_file_sb        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_reg_file_sb;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [63:0] m [16];
  logic [63:0] exp1;
  logic [63:0] exp2;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
  reg_file_sb_if #(.DATA_W(64), .ADDR_W(4)) ifb ();

  reg_file_sb #(.DATA_W(32), .NREGS(8), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifa)
  );

  reg_file_sb #(.DATA_W(64), .NREGS(16), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; errors = 0; checks = 0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    ifa.rd_addr1 = '0; ifa.rd_addr2 = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0;
    ifa.wr_data = '0; ifa.iss_en = 1'b0; ifa.iss_addr = '0;
    ifb.rd_addr1 = '0; ifb.rd_addr2 = '0; ifb.wr_en = 1'b0; ifb.wr_addr = '0;
    ifb.wr_data = '0; ifb.iss_en = 1'b0; ifb.iss_addr = '0;
    ifa.rd_addr1 = 3'd3;
    #2;
    check("reset_rd1", 64'(ifa.rd_data1), 64'h0);
    check("reset_stall", 64'(ifa.stall), 64'h0);
    tick();
    rst_n = 1'b1;

    // Mid-run reset with pending data and busy bit
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd3; ifa.wr_data = 32'h1234;
    tick();
    ifa.wr_en = 1'b0; ifa.iss_en = 1'b1; ifa.iss_addr = 3'd5;
    tick();
    ifa.iss_en = 1'b0; ifa.rd_addr1 = 3'd3; ifa.rd_addr2 = 3'd5;
    #1;
    check("pre_rst_rd1", 64'(ifa.rd_data1), 64'h1234);
    check("pre_rst_busy2", 64'(ifa.busy2), 64'h1);
    rst_n = 1'b0;
    #1;
    check("in_rst_rd1", 64'(ifa.rd_data1), 64'h0);
    ifa.rd_addr1 = 3'd5;
    #1;
    check("in_rst_busy1", 64'(ifa.busy1), 64'h0);
    check("in_rst_stall", 64'(ifa.stall), 64'h0);
    tick();
    rst_n = 1'b1;
    ifa.rd_addr2 = 3'd0;
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd5; ifa.wr_data = 32'h77;
    tick();
    ifa.wr_en = 1'b0;
    #1;
    check("late_wb_rd1", 64'(ifa.rd_data1), 64'h77);
    check("late_wb_busy1", 64'(ifa.busy1), 64'h0);

    // Same-cycle bypass
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd2; ifa.wr_data = 32'hDEADBEEF; ifa.rd_addr1 = 3'd2;
    #1;
    check("bypass_rd1", 64'(ifa.rd_data1), 64'hDEADBEEF);
    tick();
    ifa.wr_en = 1'b0;
    #1;
    check("stored_rd1", 64'(ifa.rd_data1), 64'hDEADBEEF);

    // Zero register
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd0; ifa.wr_data = 32'hFFFF_FFFF; ifa.rd_addr1 = 3'd0;
    #1;
    check("zero_bypass_rd1", 64'(ifa.rd_data1), 64'h0);
    tick();
    ifa.wr_en = 1'b0; ifa.iss_en = 1'b1; ifa.iss_addr = 3'd0;
    #1;
    check("zero_rd1", 64'(ifa.rd_data1), 64'h0);
    check("zero_iss_stall", 64'(ifa.stall), 64'h0);
    tick();
    #1;
    check("zero_iss2_stall", 64'(ifa.stall), 64'h0);
    check("zero_busy1", 64'(ifa.busy1), 64'h0);
    ifa.iss_en = 1'b0;

    // RAW hazard on R4 resolved by writeback
    ifa.iss_en = 1'b1; ifa.iss_addr = 3'd4;
    tick();
    ifa.iss_en = 1'b0; ifa.rd_addr2 = 3'd4;
    #1;
    check("raw_busy2", 64'(ifa.busy2), 64'h1);
    check("raw_stall", 64'(ifa.stall), 64'h1);
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd4; ifa.wr_data = 32'h55;
    #1;
    check("wb_busy2", 64'(ifa.busy2), 64'h0);
    check("wb_rd2", 64'(ifa.rd_data2), 64'h55);
    check("wb_stall", 64'(ifa.stall), 64'h0);
    tick();
    ifa.wr_en = 1'b0;
    #1;
    check("post_wb_busy2", 64'(ifa.busy2), 64'h0);

    // Same-edge issue and writeback to busy R6: new producer wins
    ifa.iss_en = 1'b1; ifa.iss_addr = 3'd6;
    tick();
    ifa.wr_en = 1'b1; ifa.wr_addr = 3'd6; ifa.wr_data = 32'h66;
    #1;
    check("same_edge_stall", 64'(ifa.stall), 64'h0);
    tick();
    ifa.iss_en = 1'b0; ifa.wr_en = 1'b0; ifa.rd_addr1 = 3'd6;
    #1;
    check("same_edge_busy1", 64'(ifa.busy1), 64'h1);
    check("same_edge_rd1", 64'(ifa.rd_data1), 64'h66);

    // WAW guard on R7 and ignored issue while stalled
    ifa.rd_addr1 = 3'd0; ifa.rd_addr2 = 3'd0;
    ifa.iss_en = 1'b1; ifa.iss_addr = 3'd7;
    tick();
    #1;
    check("waw_stall", 64'(ifa.stall), 64'h1);
    ifa.iss_addr = 3'd3; ifa.rd_addr1 = 3'd7;
    #1;
    check("src_stall", 64'(ifa.stall), 64'h1);
    tick();
    ifa.iss_en = 1'b0; ifa.rd_addr2 = 3'd3;
    #1;
    check("held_busy1", 64'(ifa.busy1), 64'h1);
    check("ignored_busy2", 64'(ifa.busy2), 64'h0);

    // No-bypass instance: write visible only after the edge
    ifb.wr_en = 1'b1; ifb.wr_addr = 4'd2; ifb.wr_data = 64'h0123_4567_89AB_CDEF; ifb.rd_addr1 = 4'd2;
    #1;
    check("nobyp_old_rd1", ifb.rd_data1, 64'h0);
    tick();
    m[2] = 64'h0123_4567_89AB_CDEF;
    ifb.wr_en = 1'b0;
    #1;
    check("nobyp_new_rd1", ifb.rd_data1, 64'h0123_4567_89AB_CDEF);

    // Random sweep against a reference model
    for (int k = 0; k < 200; k++) begin
      ifb.wr_en    = 1'($urandom_range(0, 1));
      ifb.wr_addr  = 4'($urandom_range(0, 15));
      ifb.wr_data  = {32'($urandom), 32'($urandom)};
      ifb.rd_addr1 = 4'($urandom_range(0, 15));
      ifb.rd_addr2 = 4'($urandom_range(0, 15));
      #1;
      exp1 = (ifb.rd_addr1 == 4'd0) ? 64'h0 : m[ifb.rd_addr1];
      exp2 = (ifb.rd_addr2 == 4'd0) ? 64'h0 : m[ifb.rd_addr2];
      check("sweep_rd1", ifb.rd_data1, exp1);
      check("sweep_rd2", ifb.rd_data2, exp2);
      if (ifb.wr_en && ifb.wr_addr != 4'd0)
        m[ifb.wr_addr] = ifb.wr_data;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
